// File: rtl/audio_switch_pkg.sv
// Shared constants for the click-free audio source selector.
package audio_switch_pkg;

  localparam int PCM_W   = 12;  // PCM sample width, signed
  localparam int NUM_SRC = 4;   // selectable sources
  localparam int SEL_W   = 2;   // source index width

  // Ramp sequencer states
  typedef enum logic [1:0] {
    ST_PLAY     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_SWITCH   = 2'd2,
    ST_FADE_IN  = 2'd3
  } ramp_state_e;

endpackage

// File: rtl/audio_sample_tick.sv
// Sample-rate divider: cnt runs 0..P-1 and tick_o is high while cnt == P-1.
module audio_sample_tick #(
  parameter int P = 520
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int CNT_W = (P > 1) ? $clog2(P) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_W'(P - 1));

  // Next count: wrap on the terminal value
  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register, synchronous reset to 0
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/audio_source_switch.sv
// Click-free audio source selector: fade out, swap source, fade in.
// Optional macro AUDIO_SWITCH_SYNC_EN: pass sel through a 2-flop synchronizer
// (for asynchronous button inputs); otherwise sel must be synchronous to clk.
module audio_source_switch
  import audio_switch_pkg::*;
#(
  parameter int C_clk_freq    = 25000000,
  parameter int C_sample_freq = 48000,
  parameter int C_ramp_shift  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel,
  input  logic signed [PCM_W-1:0] pcm0,
  input  logic signed [PCM_W-1:0] pcm1,
  input  logic signed [PCM_W-1:0] pcm2,
  input  logic signed [PCM_W-1:0] pcm3,
  output logic signed [PCM_W-1:0] pcm,
  output logic                    sample_tick,
  output logic [SEL_W-1:0]        active_sel,
  output logic                    busy
);

  localparam int P      = C_clk_freq / C_sample_freq;
  localparam int R      = C_ramp_shift;
  localparam int PROD_W = PCM_W + R + 2;
  localparam logic [R:0] GAIN_FULL = {1'b1, {R{1'b0}}};

  logic tick;

  audio_sample_tick #(.P(P)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  // ---------------------------------------------------------------- sel path
  logic [SEL_W-1:0] sel_use;

`ifdef AUDIO_SWITCH_SYNC_EN
  logic [SEL_W-1:0] sel_s1_q, sel_s2_q;

  // Two-flop synchronizer for an asynchronous selector
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_s1_q <= '0;
      sel_s2_q <= '0;
    end else begin
      sel_s1_q <= sel;
      sel_s2_q <= sel_s1_q;
    end
  end

  assign sel_use = sel_s2_q;
`else
  assign sel_use = sel;
`endif

  // ---------------------------------------------------------------- datapath
  logic signed [PCM_W-1:0]  src [NUM_SRC];
  logic signed [PCM_W-1:0]  src_cur;
  logic signed [PROD_W-1:0] src_ext, g_ext, prod;
  logic signed [PCM_W-1:0]  pcm_d;

  ramp_state_e      state_q, state_d;
  logic [R:0]       g_q, g_d;
  logic [SEL_W-1:0] act_q, act_d;
  logic signed [PCM_W-1:0] pcm_q;
  logic             tick_q;

  assign src[0]  = pcm0;
  assign src[1]  = pcm1;
  assign src[2]  = pcm2;
  assign src[3]  = pcm3;
  assign src_cur = src[act_q];

  // Gained sample: signed source times unsigned gain, arithmetic shift by R.
  // Fits in PCM_W bits because g never exceeds G.
  always_comb begin
    src_ext = PROD_W'(src_cur);
    g_ext   = PROD_W'({1'b0, g_q});
    prod    = src_ext * g_ext;
    pcm_d   = PCM_W'(prod >>> R);
  end

  // ---------------------------------------------------------------- ramp FSM
  // State, gain, routing and output sample registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FADE_IN;
      g_q     <= '0;
      act_q   <= '0;
      pcm_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      act_q   <= act_d;
      tick_q  <= tick;
      if (tick) pcm_q <= pcm_d;
    end
  end

  // Next state / gain / routing; everything moves only on tick
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    act_d   = act_q;
    if (tick) begin
      unique case (state_q)
        ST_PLAY: begin
          g_d = GAIN_FULL;
          if (sel_use != act_q) state_d = ST_FADE_OUT;
        end
        ST_FADE_OUT: begin
          if (sel_use == act_q)  state_d = ST_FADE_IN;   // reverse, no jump
          else if (g_q == '0)    state_d = ST_SWITCH;
          else                   g_d     = g_q - 1'b1;
        end
        ST_SWITCH: begin
          act_d   = sel_use;
          g_d     = '0;
          state_d = ST_FADE_IN;
        end
        ST_FADE_IN: begin
          if (sel_use != act_q) begin
            state_d = ST_FADE_OUT;
          end else if (g_q >= GAIN_FULL - 1'b1) begin
            // Saturate: a reversal straight out of PLAY re-enters here at g=G
            g_d     = GAIN_FULL;
            state_d = ST_PLAY;
          end else begin
            g_d = g_q + 1'b1;
          end
        end
        default: state_d = ST_FADE_IN;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy        = (state_q != ST_PLAY);
    pcm         = pcm_q;
    sample_tick = tick_q;
    active_sel  = act_q;
  end

endmodule
